// File: rtl/roi_pkg.sv
// roi_pkg: shared mode encodings and window record for the ROI masking pipeline.
//   ROI_CNT_MAX : storage width of window bounds (coordinate widths up to this value are supported)
//   roi_mode_e  : global output-select mode
//   roi_win_t   : one window record {hl, hr, vl, vr, en}, bounds exclusive
package roi_pkg;
  localparam int ROI_CNT_MAX = 16;
  localparam int ROI_MAX_WIN = 8;
  typedef enum logic [1:0] {
    MODE_PASS     = 2'd0,
    MODE_KEEP_IN  = 2'd1,
    MODE_BORDER   = 2'd2,
    MODE_KEEP_OUT = 2'd3
  } roi_mode_e;
  typedef struct packed {
    logic [ROI_CNT_MAX-1:0] hl;
    logic [ROI_CNT_MAX-1:0] hr;
    logic [ROI_CNT_MAX-1:0] vl;
    logic [ROI_CNT_MAX-1:0] vr;
    logic                   en;
  } roi_win_t;
endpackage

// File: rtl/roi_win_cmp.sv
// roi_win_cmp: active register set for one ROI window plus its stage-1 inside/edge compare.
//   clk, rst  : clock, asynchronous active-high reset
//   load_i    : commit strobe, copies shadow_i into the active set
//   shadow_i  : shadow window record from the top
//   hcnt_i    : horizontal coordinate of the current input pixel
//   vcnt_i    : vertical coordinate of the current input pixel
//   inside_o  : registered strict-inside flag
//   edge_o    : registered flag for the innermost ring of the window
module roi_win_cmp
  import roi_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  roi_win_t         shadow_i,
  input  logic [CNT_W-1:0] hcnt_i,
  input  logic [CNT_W-1:0] vcnt_i,
  output logic             inside_o,
  output logic             edge_o
);
  localparam logic [ROI_CNT_MAX-1:0] ONE = ROI_CNT_MAX'(1);
  roi_win_t               act_q;
  logic [ROI_CNT_MAX-1:0] h, v;
  logic                   inside_d, edge_d;
  // Bounds are compared at full record width so hl+1 / hr-1 never alias onto a valid
  // coordinate through wrap-around; such cases are already excluded by inside_d.
  always_comb begin
    h        = ROI_CNT_MAX'(hcnt_i);
    v        = ROI_CNT_MAX'(vcnt_i);
    inside_d = act_q.en && (act_q.hl < h) && (h < act_q.hr) && (act_q.vl < v) && (v < act_q.vr);
    edge_d   = inside_d && ((h == act_q.hl + ONE) || (h == act_q.hr - ONE) ||
                            (v == act_q.vl + ONE) || (v == act_q.vr - ONE));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q    <= '0;
      inside_o <= 1'b0;
      edge_o   <= 1'b0;
    end else begin
      if (load_i) act_q <= shadow_i;
      inside_o <= inside_d;
      edge_o   <= edge_d;
    end
  end
endmodule

// File: rtl/roi_window_mask.sv
// roi_window_mask: two-stage video pipeline that masks, keeps or outlines up to NUM_WIN rectangular ROIs.
//   pixelclk, reset                 : pixel clock, asynchronous active-high reset
//   i_rgb/i_hsync/i_vsync/i_de      : input video (syncs active-high)
//   cfg_wr/cfg_idx                  : shadow write strobe and target window
//   cfg_hl/cfg_hr/cfg_vl/cfg_vr     : exclusive window bounds
//   cfg_en/cfg_mode                 : window enable, global mode (sampled only at commit)
//   o_rgb/o_hsync/o_vsync/o_de      : processed video, 2-cycle latency
//   o_hit                           : per-window inside flags aligned with o_rgb
//   o_frame_start                   : one-cycle pulse on each shadow-to-active commit
module roi_window_mask
  import roi_pkg::*;
#(
  parameter int                DATA_W       = 24,
  parameter int                CNT_W        = 12,
  parameter int                NUM_WIN      = 4,
  parameter logic [DATA_W-1:0] FILL_COLOR   = 24'h00FFFF,
  parameter logic [DATA_W-1:0] BORDER_COLOR = 24'hFF0000
) (
  input  logic               pixelclk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  i_rgb,
  input  logic               i_hsync,
  input  logic               i_vsync,
  input  logic               i_de,
  input  logic               cfg_wr,
  input  logic [2:0]         cfg_idx,
  input  logic [CNT_W-1:0]   cfg_hl,
  input  logic [CNT_W-1:0]   cfg_hr,
  input  logic [CNT_W-1:0]   cfg_vl,
  input  logic [CNT_W-1:0]   cfg_vr,
  input  logic               cfg_en,
  input  logic [1:0]         cfg_mode,
  output logic [DATA_W-1:0]  o_rgb,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_de,
  output logic [NUM_WIN-1:0] o_hit,
  output logic               o_frame_start
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [CNT_W-1:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic               de_prev_q, vs_prev_q, commit_q;
  logic               vs_rise, de_fall;
  roi_win_t           win_d;
  roi_win_t           shadow_q [NUM_WIN];
  roi_mode_e          mode_q, mode1_q;
  logic [DATA_W-1:0]  rgb1_q, rgb_d;
  logic               hs1_q, vs1_q, de1_q;
  logic [NUM_WIN-1:0] inside1, edge1;
  logic               in_any, edge_any;
  // hcnt_q/vcnt_q always hold the coordinate of the pixel currently on the inputs.
  always_comb begin
    vs_rise = i_vsync & ~vs_prev_q;
    de_fall = de_prev_q & ~i_de;
    hcnt_d  = i_de ? ((&hcnt_q) ? hcnt_q : hcnt_q + ONE) : '0;
    vcnt_d  = vs_rise ? '0 : (de_fall && !(&vcnt_q)) ? vcnt_q + ONE : vcnt_q;
    win_d   = '{hl: ROI_CNT_MAX'(cfg_hl), hr: ROI_CNT_MAX'(cfg_hr),
                vl: ROI_CNT_MAX'(cfg_vl), vr: ROI_CNT_MAX'(cfg_vr), en: cfg_en};
  end
  // commit_q is the cycle after the vsync rising edge; active loads at its end, so a
  // shadow write landing on the same edge is seen only by the following commit.
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      de_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      commit_q  <= 1'b0;
      mode_q    <= MODE_PASS;
      for (int k = 0; k < NUM_WIN; k++) shadow_q[k] <= '0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      de_prev_q <= i_de;
      vs_prev_q <= i_vsync;
      commit_q  <= vs_rise;
      if (commit_q) mode_q <= roi_mode_e'(cfg_mode);
      for (int k = 0; k < NUM_WIN; k++)
        if (cfg_wr && (32'(cfg_idx) == k)) shadow_q[k] <= win_d;
    end
  end
  assign o_frame_start = commit_q;
  for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
    roi_win_cmp #(.CNT_W(CNT_W)) u_win (
      .clk      (pixelclk),
      .rst      (reset),
      .load_i   (commit_q),
      .shadow_i (shadow_q[i]),
      .hcnt_i   (hcnt_q),
      .vcnt_i   (vcnt_q),
      .inside_o (inside1[i]),
      .edge_o   (edge1[i])
    );
  end
  // Mode travels with the pixel so a commit cannot change the treatment of pixels in flight.
  always_comb begin
    in_any   = |inside1;
    edge_any = |edge1;
    rgb_d    = !de1_q                     ? '0 :
               (mode1_q == MODE_KEEP_IN)  ? (in_any ? rgb1_q : FILL_COLOR) :
               (mode1_q == MODE_BORDER)   ? (edge_any ? BORDER_COLOR : rgb1_q) :
               (mode1_q == MODE_KEEP_OUT) ? (in_any ? FILL_COLOR : rgb1_q) : rgb1_q;
  end
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      rgb1_q  <= '0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      de1_q   <= 1'b0;
      mode1_q <= MODE_PASS;
      o_rgb   <= '0;
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
      o_de    <= 1'b0;
      o_hit   <= '0;
    end else begin
      rgb1_q  <= i_rgb;
      hs1_q   <= i_hsync;
      vs1_q   <= i_vsync;
      de1_q   <= i_de;
      mode1_q <= mode_q;
      o_rgb   <= rgb_d;
      o_hsync <= hs1_q;
      o_vsync <= vs1_q;
      o_de    <= de1_q;
      o_hit   <= inside1;
    end
  end
endmodule
